// File: rtl/draw_hp_bar_pkg.sv
// Shared HP-bar geometry, colours and controller state encoding.
// Imported by the background drawer and the HP overlay so both agree on the frame.
package draw_hp_bar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIVE = 2'd1,
        ST_INVUL = 2'd2,
        ST_DEAD  = 2'd3
    } hp_state_e;

    localparam logic [11:0] HP_LEFT   = 12'd361;
    localparam logic [11:0] HP_TOP    = 12'd717;
    localparam logic [11:0] HP_BOTTOM = 12'd757;

    localparam logic [8:0] MAX_HP = 9'd300;
    localparam logic [8:0] DAMAGE = 9'd25;
    localparam logic [8:0] LOW_HP = 9'd75;

    localparam logic [7:0] INVUL_FRAMES = 8'd60;

    localparam logic [11:0] HP_RIGHT = HP_LEFT + {3'b000, MAX_HP};

    localparam logic [11:0] COL_FULL  = 12'h0f0;
    localparam logic [11:0] COL_LOW   = 12'hf00;
    localparam logic [11:0] COL_EMPTY = 12'h400;

endpackage

// File: rtl/draw_hp_bar_hp_ctrl.sv
// Health controller: frame tick, HP counter, displayed HP, invulnerability
// timer and game-over flag.
module draw_hp_bar_hp_ctrl
    import draw_hp_bar_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        vblnk_i,
    input  logic        mouse_mode_i,
    input  logic        hit_i,
    output hp_state_e   state_o,
    output logic [8:0]  hp_o,
    output logic [8:0]  hp_disp_o,
    output logic [7:0]  invul_cnt_o,
    output logic        game_over_o
);

    hp_state_e   state_q;
    logic [8:0]  hp_q;
    logic [8:0]  hp_disp_q;
    logic [7:0]  invul_q;
    logic        game_over_q;
    logic        vblnk_q;

    logic        frame_tick;
    logic [8:0]  hp_hit_d;

    assign frame_tick = vblnk_i & ~vblnk_q;
    assign hp_hit_d   = (hp_q > DAMAGE) ? (hp_q - DAMAGE) : 9'd0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            hp_q        <= MAX_HP;
            hp_disp_q   <= MAX_HP;
            invul_q     <= 8'd0;
            game_over_q <= 1'b0;
            vblnk_q     <= 1'b0;
        end else begin
            vblnk_q <= vblnk_i;
            // Displayed HP samples the pre-hit value so a frame never tears.
            if (frame_tick) begin
                hp_disp_q <= hp_q;
            end
            if (!mouse_mode_i) begin
                state_q     <= ST_IDLE;
                hp_q        <= MAX_HP;
                invul_q     <= 8'd0;
                game_over_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        hp_q    <= MAX_HP;
                        state_q <= ST_ALIVE;
                    end
                    ST_ALIVE: begin
                        if (hit_i) begin
                            hp_q <= hp_hit_d;
                            if (hp_hit_d == 9'd0) begin
                                state_q     <= ST_DEAD;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= ST_INVUL;
                                invul_q <= INVUL_FRAMES;
                            end
                        end
                    end
                    ST_INVUL: begin
                        if (frame_tick) begin
                            invul_q <= invul_q - 8'd1;
                            if (invul_q == 8'd1) begin
                                state_q <= ST_ALIVE;
                            end
                        end
                    end
                    ST_DEAD: begin
                        hp_q        <= 9'd0;
                        game_over_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign state_o     = state_q;
    assign hp_o        = hp_q;
    assign hp_disp_o   = hp_disp_q;
    assign invul_cnt_o = invul_q;
    assign game_over_o = game_over_q;

endmodule

// File: rtl/draw_hp_bar.sv
// HP-bar overlay stage: composites the health fill over the background
// stream and forwards timing with one cycle of latency.
module draw_hp_bar
    import draw_hp_bar_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        mouse_mode,
    input  logic        hit,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [8:0]  hp,
    output logic        game_over
);

    hp_state_e   state;
    logic [8:0]  hp_disp;
    logic [7:0]  invul_cnt;

    logic [11:0] fill_end;
    logic        interior;
    logic        blink;
    logic [11:0] rgb_d;

    draw_hp_bar_hp_ctrl u_hp_ctrl (
        .clk_i        (pclk),
        .rst_ni       (rst),
        .vblnk_i      (vblnk_in),
        .mouse_mode_i (mouse_mode),
        .hit_i        (hit),
        .state_o      (state),
        .hp_o         (hp),
        .hp_disp_o    (hp_disp),
        .invul_cnt_o  (invul_cnt),
        .game_over_o  (game_over)
    );

    assign fill_end = HP_LEFT + {3'b000, hp_disp};
    assign interior = (hcount_in >= HP_LEFT) && (hcount_in < HP_RIGHT)
                   && (vcount_in >= HP_TOP) && (vcount_in < HP_BOTTOM);
    assign blink    = (state == ST_INVUL) && invul_cnt[2];

    always_comb begin
        rgb_d = rgb_in;
        if (!hblnk_in && !vblnk_in && state != ST_IDLE && interior) begin
            if (hcount_in < fill_end && !blink) begin
                rgb_d = (hp_disp <= LOW_HP) ? COL_LOW : COL_FULL;
            end else begin
                rgb_d = COL_EMPTY;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            hcount_out <= 12'd0;
            vcount_out <= 12'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_d;
        end
    end

endmodule
